// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller sequencing each fetched instruction through FETCH/DCD/EXE/MEM/WB.
module mc_ctrl #(
  parameter logic [31:0] RESET_IR = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  output logic [31:0]      IR,
  output logic [2:0]       State,
  output logic             PCWr,
  output logic [1:0]       PCControl,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic             MemWr,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCnt
);
  typedef enum logic [2:0] {FETCH = 3'd0, DCD = 3'd1, EXE = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0] op, fn;
  logic is_r, is_addu, is_subu, is_jr, is_nop, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, is_ill;
  logic pc_wr, reg_wr, mem_wr, ill;
  logic [1:0] pc_ctrl;
  assign op      = ir_q[31:26];
  assign fn      = ir_q[5:0];
  assign is_nop  = ir_q == 32'h0;
  assign is_r    = op == 6'b000000;
  assign is_addu = is_r && fn == 6'b100001;
  assign is_subu = is_r && fn == 6'b100011;
  assign is_jr   = is_r && fn == 6'b001000;
  assign is_ori  = op == 6'b001101;
  assign is_lw   = op == 6'b100011;
  assign is_sw   = op == 6'b101011;
  assign is_beq  = op == 6'b000100;
  assign is_lui  = op == 6'b001111;
  assign is_j    = op == 6'b000010;
  assign is_jal  = op == 6'b000011;
  assign is_ill  = !(is_nop || is_addu || is_subu || is_jr || is_ori || is_lw || is_sw ||
                     is_beq || is_lui || is_j || is_jal);
  always_comb begin
    RegDst   = is_jal ? 2'b10 : (is_addu || is_subu) ? 2'b01 : 2'b00;
    MemToReg = is_jal ? 2'b10 : is_lw ? 2'b01 : 2'b00;
    ALUSrc   = is_ori || is_lui || is_lw || is_sw;
    ALUOp    = (is_subu || is_beq) ? 2'b01 : (is_ori || is_lui) ? 2'b10 : 2'b00;
    ExtOp    = is_lui ? 2'b10 : (is_lw || is_sw) ? 2'b01 : 2'b00;
  end
  always_comb begin
    state_d = FETCH;
    ir_d    = ir_q;
    pc_wr   = 1'b0;
    pc_ctrl = 2'b00;
    reg_wr  = 1'b0;
    mem_wr  = 1'b0;
    ill     = 1'b0;
    case (state_q)
      FETCH: begin
        ir_d    = Instr;
        state_d = DCD;
      end
      DCD: begin
        if (is_j || is_jal || is_jr || is_nop || is_ill) begin
          pc_wr   = 1'b1;
          pc_ctrl = (is_j || is_jal) ? 2'b11 : is_jr ? 2'b10 : 2'b00;
          reg_wr  = is_jal;
          ill     = is_ill;
        end else state_d = EXE;
      end
      EXE: begin
        if (is_beq) begin
          pc_wr   = 1'b1;
          pc_ctrl = Zero ? 2'b01 : 2'b00;
        end else state_d = (is_lw || is_sw) ? MEM : WB;
      end
      MEM: begin
        if (is_sw) begin
          mem_wr = 1'b1;
          pc_wr  = 1'b1;
        end else state_d = WB;
      end
      WB: begin
        reg_wr = 1'b1;
        pc_wr  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end
  // Clr suppresses every commit strobe so an interrupted instruction leaves no side effects.
  assign PCWr      = pc_wr && !Clr;
  assign RegWr     = reg_wr && !Clr;
  assign MemWr     = mem_wr && !Clr;
  assign Illegal   = ill && !Clr;
  assign PCControl = pc_ctrl;
  assign IR        = ir_q;
  assign State     = state_q;
  assign InstrCnt  = cnt_q;
  assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, PCWr};
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= FETCH;
      ir_q    <= RESET_IR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of mc_ctrl sequencing, strobes, selects, reset and counter wrap.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        clr, zero;
  logic [31:0] instr, ir;
  logic [2:0]  state;
  logic        pc_wr, reg_wr, alu_src, mem_wr, illegal;
  logic [1:0]  pc_ctrl, reg_dst, mem_to_reg, alu_op, ext_op;
  logic [31:0] cnt;
  logic [31:0] w_ir;
  logic [2:0]  w_state, w_cnt;
  logic        w_pc_wr, w_reg_wr, w_alu_src, w_mem_wr, w_ill;
  logic [1:0]  w_pc_ctrl, w_reg_dst, w_m2r, w_alu_op, w_ext_op;
  int checks = 0, errors = 0;
  localparam logic [31:0] LUI = 32'h3C01_1234, LW = 32'h8C22_0004, SW = 32'hAC22_0004,
                          BEQ = 32'h1022_0003, JAL = 32'h0C00_0C00, JR = 32'h03E0_0008,
                          ILL = 32'hFC00_0000, ADDU = 32'h0022_1821;
  always #5 clk = ~clk;
  mc_ctrl dut (
    .Clk(clk), .Clr(clr), .Instr(instr), .Zero(zero), .IR(ir), .State(state), .PCWr(pc_wr),
    .PCControl(pc_ctrl), .RegWr(reg_wr), .RegDst(reg_dst), .MemToReg(mem_to_reg), .ALUSrc(alu_src),
    .ALUOp(alu_op), .ExtOp(ext_op), .MemWr(mem_wr), .Illegal(illegal), .InstrCnt(cnt)
  );
  mc_ctrl #(.CNT_W(3)) dut_w (
    .Clk(clk), .Clr(clr), .Instr(instr), .Zero(zero), .IR(w_ir), .State(w_state), .PCWr(w_pc_wr),
    .PCControl(w_pc_ctrl), .RegWr(w_reg_wr), .RegDst(w_reg_dst), .MemToReg(w_m2r), .ALUSrc(w_alu_src),
    .ALUOp(w_alu_op), .ExtOp(w_ext_op), .MemWr(w_mem_wr), .Illegal(w_ill), .InstrCnt(w_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [2:0] st, input logic pw, input logic [1:0] pc,
                      input logic rw, input logic mw, input logic il);
    @(posedge clk);
    #2;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/pcwr"}, 32'(pc_wr), 32'(pw));
    if (pw) check({tag, "/pcctl"}, 32'(pc_ctrl), 32'(pc));
    check({tag, "/regwr"}, 32'(reg_wr), 32'(rw));
    check({tag, "/memwr"}, 32'(mem_wr), 32'(mw));
    check({tag, "/illegal"}, 32'(illegal), 32'(il));
  endtask
  initial begin
    clr = 1'b1; instr = 32'h0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst/state", 32'(state), 32'd0);
    check("rst/ir", ir, 32'h0);
    check("rst/cnt", cnt, 32'd0);
    check("rst/pcwr", 32'(pc_wr), 32'd0);
    check("rst/pcctl", 32'(pc_ctrl), 32'd0);
    check("rst/regdst", 32'(reg_dst), 32'd0);
    check("rst/extop", 32'(ext_op), 32'd0);
    clr = 1'b0; instr = LUI;
    step("lui_dcd", 3'd1, 0, 2'b00, 0, 0, 0);
    check("lui/ir", ir, LUI);
    step("lui_exe", 3'd2, 0, 2'b00, 0, 0, 0);
    step("lui_wb", 3'd4, 1, 2'b00, 1, 0, 0);
    check("lui/regdst", 32'(reg_dst), 32'd0);
    check("lui/extop", 32'(ext_op), 32'd2);
    check("lui/alusrc", 32'(alu_src), 32'd1);
    check("lui/aluop", 32'(alu_op), 32'd2);
    instr = LW;
    step("lw_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt1", cnt, 32'd1);
    step("lw_dcd", 3'd1, 0, 2'b00, 0, 0, 0);
    step("lw_exe", 3'd2, 0, 2'b00, 0, 0, 0);
    step("lw_mem", 3'd3, 0, 2'b00, 0, 0, 0);
    step("lw_wb", 3'd4, 1, 2'b00, 1, 0, 0);
    check("lw/m2r", 32'(mem_to_reg), 32'd1);
    check("lw/extop", 32'(ext_op), 32'd1);
    check("lw/aluop", 32'(alu_op), 32'd0);
    instr = SW;
    step("sw_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt2", cnt, 32'd2);
    step("sw_dcd", 3'd1, 0, 2'b00, 0, 0, 0);
    step("sw_exe", 3'd2, 0, 2'b00, 0, 0, 0);
    step("sw_mem", 3'd3, 1, 2'b00, 0, 1, 0);
    instr = BEQ;
    step("beq1_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt3", cnt, 32'd3);
    zero = 1'b0;
    step("beq1_dcd", 3'd1, 0, 2'b00, 0, 0, 0);
    zero = 1'b1;
    step("beq1_exe", 3'd2, 1, 2'b01, 0, 0, 0);
    check("beq/aluop", 32'(alu_op), 32'd1);
    step("beq2_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt4", cnt, 32'd4);
    step("beq2_dcd", 3'd1, 0, 2'b00, 0, 0, 0);
    zero = 1'b0;
    step("beq2_exe", 3'd2, 1, 2'b00, 0, 0, 0);
    instr = JAL;
    step("jal_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt5", cnt, 32'd5);
    step("jal_dcd", 3'd1, 1, 2'b11, 1, 0, 0);
    check("jal/regdst", 32'(reg_dst), 32'd2);
    check("jal/m2r", 32'(mem_to_reg), 32'd2);
    instr = JR;
    step("jr_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt6", cnt, 32'd6);
    step("jr_dcd", 3'd1, 1, 2'b10, 0, 0, 0);
    instr = ILL;
    step("ill_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt7", cnt, 32'd7);
    check("wcnt7", 32'(w_cnt), 32'd7);
    step("ill_dcd", 3'd1, 1, 2'b00, 0, 0, 1);
    instr = 32'h0;
    step("nop_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt8", cnt, 32'd8);
    check("wcnt_wrap", 32'(w_cnt), 32'd0);
    step("nop_dcd", 3'd1, 1, 2'b00, 0, 0, 0);
    instr = ADDU;
    step("addu_fetch", 3'd0, 0, 2'b00, 0, 0, 0);
    check("cnt9", cnt, 32'd9);
    step("addu_dcd", 3'd1, 0, 2'b00, 0, 0, 0);
    check("addu/regdst", 32'(reg_dst), 32'd1);
    step("addu_exe", 3'd2, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    check("clr_wb/state", 32'(state), 32'd4);
    check("clr_wb/regwr", 32'(reg_wr), 32'd0);
    check("clr_wb/pcwr", 32'(pc_wr), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    #1;
    check("clr/state", 32'(state), 32'd0);
    check("clr/ir", ir, 32'h0);
    check("clr/cnt", cnt, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
